// File: rtl/snitch_icache_tag_array.sv
// Multi-way icache tag store: handshaked lookup with way-hit compare, refill writes,
// post-reset invalidation and walking flush. Optional parity: SNITCH_ICACHE_TAG_PARITY_EN.
module snitch_icache_tag_array #(
  parameter int unsigned WAY_COUNT  = 4,
  parameter int unsigned LINE_COUNT = 128,
  parameter int unsigned TAG_WIDTH  = 20,
  parameter type sram_cfg_tag_t = logic,
  localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  sram_cfg_tag_t          sram_cfg_i,
  input  logic                   flush_valid_i,
  output logic                   flush_ready_o,
  input  logic                   lookup_valid_i,
  output logic                   lookup_ready_o,
  input  logic [COUNT_ALIGN-1:0] lookup_addr_i,
  input  logic [TAG_WIDTH-1:0]   lookup_tag_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic [WAY_COUNT-1:0]   rsp_way_o,
  output logic                   rsp_error_o,
  input  logic                   write_valid_i,
  output logic                   write_ready_o,
  input  logic [COUNT_ALIGN-1:0] write_addr_i,
  input  logic [WAY_COUNT-1:0]   write_way_i,
  input  logic [TAG_WIDTH-1:0]   write_tag_i,
  input  logic                   write_error_i,
  output logic                   busy_o
);

`ifdef SNITCH_ICACHE_TAG_PARITY_EN
  localparam int unsigned EntryW = TAG_WIDTH + 3;
`else
  localparam int unsigned EntryW = TAG_WIDTH + 2;
`endif
  localparam logic [COUNT_ALIGN-1:0] LastLine = COUNT_ALIGN'(LINE_COUNT - 1);

  typedef enum logic [1:0] {StInit, StIdle, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_ALIGN-1:0] cnt_q, cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;

  logic [WAY_COUNT-1:0]   sram_req;
  logic                   sram_we;
  logic [COUNT_ALIGN-1:0] sram_addr;
  logic [EntryW-1:0]      sram_wdata;
  logic [EntryW-1:0]      write_entry;
  logic                   stall;

  logic unused_cfg;
  assign unused_cfg = ^sram_cfg_i;

`ifdef SNITCH_ICACHE_TAG_PARITY_EN
  assign write_entry = {^{1'b1, write_error_i, write_tag_i}, 1'b1, write_error_i, write_tag_i};
`else
  assign write_entry = {1'b1, write_error_i, write_tag_i};
`endif

  assign stall  = rsp_valid_q & ~rsp_ready_i;
  assign busy_o = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tag_d          = tag_q;
    sram_req       = '0;
    sram_we        = 1'b0;
    sram_addr      = '0;
    sram_wdata     = '0;
    flush_ready_o  = 1'b0;
    write_ready_o  = (state_q == StIdle) & ~flush_valid_i & ~stall;
    lookup_ready_o = (state_q == StIdle) & ~flush_valid_i & ~write_valid_i & ~stall;
    unique case (state_q)
      StInit, StFlush: begin
        sram_req  = '1;
        sram_we   = 1'b1;
        sram_addr = cnt_q;
        cnt_d     = cnt_q + COUNT_ALIGN'(1);
        if (cnt_q == LastLine) begin
          state_d       = StIdle;
          flush_ready_o = (state_q == StFlush);
        end
      end
      StIdle: begin
        if (flush_valid_i && !stall) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else if (write_valid_i && write_ready_o) begin
          sram_req   = write_way_i;
          sram_we    = 1'b1;
          sram_addr  = write_addr_i;
          sram_wdata = write_entry;
        end else if (lookup_valid_i && lookup_ready_o) begin
          sram_req  = '1;
          sram_addr = lookup_addr_i;
          tag_d     = lookup_tag_i;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (lookup_valid_i && lookup_ready_o) begin
      rsp_valid_d = 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      tag_q       <= tag_d;
    end
  end

  // Per-way single-port tag SRAMs, read latency 1; read data holds when not requested.
  logic [EntryW-1:0] tag_mem [WAY_COUNT][LINE_COUNT];
  logic [EntryW-1:0] rdata_q [WAY_COUNT];

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (sram_req[w]) begin
        if (sram_we) begin
          tag_mem[w][sram_addr] <= sram_wdata;
        end else begin
          rdata_q[w] <= tag_mem[w][sram_addr];
        end
      end
    end
  end

  logic [WAY_COUNT-1:0] hit, way_err;
  logic                 multi_hit;

  always_comb begin
    for (int w = 0; w < WAY_COUNT; w++) begin
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
      logic par_ok;
      par_ok = ~^rdata_q[w];
`else
      logic par_ok;
      par_ok = 1'b1;
`endif
      hit[w]     = rdata_q[w][TAG_WIDTH+1] & (rdata_q[w][TAG_WIDTH-1:0] == tag_q) & par_ok;
      way_err[w] = (hit[w] & rdata_q[w][TAG_WIDTH]) | ~par_ok;
    end
    multi_hit = |(hit & (hit - WAY_COUNT'(1)));
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_way_o   = rsp_valid_q ? hit : '0;
  assign rsp_hit_o   = rsp_valid_q & (|hit);
  assign rsp_error_o = rsp_valid_q & ((|way_err) | multi_hit);

endmodule

// File: tb/tb_snitch_icache_tag_array.sv
// Scoreboard bench for snitch_icache_tag_array: reference tag model predicts each lookup
// response when accepted; responses are compared in order as they are consumed.
module tb_snitch_icache_tag_array;
  localparam int W = 4;
  localparam int L = 128;
  localparam int T = 20;
  localparam int A = 7;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         sram_cfg_i = 1'b0;
  logic         flush_valid_i = 1'b0;
  logic         flush_ready_o;
  logic         lookup_valid_i = 1'b0;
  logic         lookup_ready_o;
  logic [A-1:0] lookup_addr_i = '0;
  logic [T-1:0] lookup_tag_i = '0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b1;
  logic         rsp_hit_o;
  logic [W-1:0] rsp_way_o;
  logic         rsp_error_o;
  logic         write_valid_i = 1'b0;
  logic         write_ready_o;
  logic [A-1:0] write_addr_i = '0;
  logic [W-1:0] write_way_i = '0;
  logic [T-1:0] write_tag_i = '0;
  logic         write_error_i = 1'b0;
  logic         busy_o;

  snitch_icache_tag_array #(
    .WAY_COUNT (W),
    .LINE_COUNT(L),
    .TAG_WIDTH (T)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sram_cfg_i    (sram_cfg_i),
    .flush_valid_i (flush_valid_i),
    .flush_ready_o (flush_ready_o),
    .lookup_valid_i(lookup_valid_i),
    .lookup_ready_o(lookup_ready_o),
    .lookup_addr_i (lookup_addr_i),
    .lookup_tag_i  (lookup_tag_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_hit_o     (rsp_hit_o),
    .rsp_way_o     (rsp_way_o),
    .rsp_error_o   (rsp_error_o),
    .write_valid_i (write_valid_i),
    .write_ready_o (write_ready_o),
    .write_addr_i  (write_addr_i),
    .write_way_i   (write_way_i),
    .write_tag_i   (write_tag_i),
    .write_error_i (write_error_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic         hit;
    logic [W-1:0] way;
    logic         err;
  } rsp_t;

  rsp_t         sb_q[$];
  logic [T+1:0] model [W][L];  // {valid, error, tag}
  logic         par_inj = 1'b0;

  function automatic rsp_t expect_rsp(input logic [A-1:0] a, input logic [T-1:0] t);
    rsp_t r;
    int   n;
    r = '0;
    n = 0;
    for (int w = 0; w < W; w++) begin
      if (model[w][a][T+1] && model[w][a][T-1:0] == t) begin
        r.way[w] = 1'b1;
        r.err    = r.err | model[w][a][T];
        n++;
      end
    end
    r.hit = (n != 0);
    if (n > 1) r.err = 1'b1;
    if (par_inj) r = '{hit: 1'b0, way: '0, err: 1'b1};
    return r;
  endfunction

  task automatic clear_model();
    for (int w = 0; w < W; w++)
      for (int l = 0; l < L; l++) model[w][l] = '0;
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      clear_model();
      sb_q.delete();
    end else begin
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = sb_q.pop_front();
          check_eq("rsp_hit", {31'd0, rsp_hit_o}, {31'd0, e.hit});
          check_eq("rsp_way", {28'd0, rsp_way_o}, {28'd0, e.way});
          check_eq("rsp_err", {31'd0, rsp_error_o}, {31'd0, e.err});
        end
      end
      if (write_valid_i && write_ready_o) begin
        for (int w = 0; w < W; w++)
          if (write_way_i[w]) model[w][write_addr_i] = {1'b1, write_error_i, write_tag_i};
      end
      if (lookup_valid_i && lookup_ready_o) sb_q.push_back(expect_rsp(lookup_addr_i, lookup_tag_i));
      if (flush_ready_o) clear_model();
    end
  end

  task automatic do_lookup(input logic [A-1:0] a, input logic [T-1:0] t);
    int n = 0;
    lookup_valid_i = 1'b1;
    lookup_addr_i  = a;
    lookup_tag_i   = t;
    @(negedge clk_i);
    while (!lookup_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) check_eq("lookup_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    lookup_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("rsp_latency", {31'd0, rsp_valid_o}, 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] way, input logic [T-1:0] t,
                          input logic err);
    int n = 0;
    write_valid_i = 1'b1;
    write_addr_i  = a;
    write_way_i   = way;
    write_tag_i   = t;
    write_error_i = err;
    @(negedge clk_i);
    while (!write_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) check_eq("write_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    write_valid_i = 1'b0;
  endtask

  // Counts busy cycles from now until busy drops; lookup_ready must stay low meanwhile.
  task automatic count_busy(input string name);
    int n = 0;
    int rdy = 0;
    @(negedge clk_i);
    while (busy_o && n < 2000) begin
      n++;
      if (lookup_ready_o || write_ready_o) rdy++;
      @(negedge clk_i);
    end
    check_eq({name, "_cycles"}, n, L);
    check_eq({name, "_ready_low"}, rdy, 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("reset_busy", {31'd0, busy_o}, 32'd1);
    check_eq("reset_outs", {26'd0, flush_ready_o, lookup_ready_o, write_ready_o, rsp_valid_o,
                            rsp_hit_o, rsp_error_o}, 32'd0);
    check_eq("reset_way", {28'd0, rsp_way_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    count_busy("init");

    do_lookup(7'd5, 20'hABCDE);
    do_write(7'd5, 4'b0100, 20'hABCDE, 1'b0);
    do_lookup(7'd5, 20'hABCDE);
    check_eq("idle_zero", {28'd0, rsp_hit_o, rsp_error_o, rsp_valid_o, |rsp_way_o}, 32'd0);
    do_lookup(7'd5, 20'hABCDF);

    // Backpressure: second lookup waits while the first response is stalled.
    rsp_ready_i    = 1'b0;
    lookup_valid_i = 1'b1;
    lookup_addr_i  = 7'd5;
    lookup_tag_i   = 20'hABCDE;
    @(negedge clk_i);
    check_eq("bp_accept_a", {31'd0, lookup_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    lookup_tag_i = 20'hABCDF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("bp_stall_valid", {31'd0, rsp_valid_o}, 32'd1);
      check_eq("bp_stall_way", {28'd0, rsp_way_o}, 32'd4);
      check_eq("bp_stall_ready", {30'd0, lookup_ready_o, write_ready_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check_eq("bp_accept_b", {31'd0, lookup_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    lookup_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("bp_rsp_b", {30'd0, rsp_valid_o, rsp_hit_o}, 32'd2);
    @(posedge clk_i);
    #1;

    do_write(7'd7, 4'b0101, 20'h12345, 1'b0);
    do_lookup(7'd7, 20'h12345);
    do_write(7'd9, 4'b0010, 20'h55555, 1'b1);
    do_lookup(7'd9, 20'h55555);
    do_write(7'd9, 4'b0000, 20'h55555, 1'b0);
    do_lookup(7'd9, 20'h55555);
    do_write(7'd127, 4'b1000, 20'hFFFFF, 1'b0);
    do_lookup(7'd127, 20'hFFFFF);

    // Flush racing a write: flush wins, write never accepted during the walk.
    begin
      int n = 0;
      int saw_wr = 0;
      flush_valid_i = 1'b1;
      write_valid_i = 1'b1;
      write_addr_i  = 7'd5;
      write_way_i   = 4'b0001;
      write_tag_i   = 20'h99999;
      write_error_i = 1'b0;
      @(negedge clk_i);
      check_eq("flush_wins_write", {31'd0, write_ready_o}, 32'd0);
      while (!flush_ready_o && n < 2000) begin
        @(negedge clk_i);
        if (busy_o) n++;
        if (write_ready_o) saw_wr++;
      end
      check_eq("flush_cycles", n, L);
      check_eq("flush_no_write", saw_wr, 0);
      @(posedge clk_i);
      #1;
      flush_valid_i = 1'b0;
      write_valid_i = 1'b0;
      @(negedge clk_i);
      check_eq("flush_idle", {30'd0, busy_o, flush_ready_o}, 32'd0);
      @(posedge clk_i);
      #1;
    end
    do_lookup(7'd5, 20'hABCDE);
    do_lookup(7'd7, 20'h12345);
    do_lookup(7'd127, 20'hFFFFF);

    // Reset in the middle of a flush restarts the full invalidation walk.
    do_write(7'd3, 4'b0001, 20'h00777, 1'b0);
    flush_valid_i = 1'b1;
    repeat (60) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("rst_mid_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_i         = 1'b0;
    flush_valid_i = 1'b0;
    count_busy("reinit");
    do_lookup(7'd3, 20'h00777);

`ifdef SNITCH_ICACHE_TAG_PARITY_EN
    do_write(7'd11, 4'b0010, 20'h0F0F0, 1'b0);
    dut.tag_mem[1][11] = dut.tag_mem[1][11] ^ (23'd1 << 22);
    par_inj = 1'b1;
    do_lookup(7'd11, 20'h0F0F0);
    par_inj = 1'b0;
`endif

    repeat (3) @(negedge clk_i);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/snitch_icache_tag_array.md
# snitch_icache_tag_array

- Multi-way instruction-cache tag store with lookup, refill-write and flush control built around per-way single-port tag SRAMs.
- Sits between the L0/L1 icache lookup pipeline and the refill unit.
- Adds over a bare tag memory: handshaked lookups with way-hit compare, automatic post-reset invalidation, and a walking flush state machine.

## Interface

Parameters:
- WAY_COUNT, 4, number of ways (one SRAM each)
- LINE_COUNT, 128, sets per way (power of two, ≥2)
- TAG_WIDTH, 20, tag bits
- sram_cfg_tag_t, logic, SRAM implementation config type
- COUNT_ALIGN (localparam), $clog2(LINE_COUNT)

Ports:
- **Clock and reset:** one clock; reset is asynchronous and active-high.
  - clk_i  in  1  clock
  - rst_i  in  1  asynchronous reset, active-high
- **SRAM config:** sram_cfg_i  in  sram_cfg_tag_t  passed to every SRAM
- **Flush:**
  - flush_valid_i  in  1  flush request; held until flush_ready_o
  - flush_ready_o  out  1  one-cycle pulse on flush completion
- **Lookup request:**
  - lookup_valid_i / lookup_ready_o  in / out  1  lookup handshake
  - lookup_addr_i  in  COUNT_ALIGN  set index
  - lookup_tag_i  in  TAG_WIDTH  tag to compare
- **Lookup response:**
  - rsp_valid_o / rsp_ready_i  out / in  1  response handshake
  - rsp_hit_o  out  1  any way hit
  - rsp_way_o  out  WAY_COUNT  hitting ways (one-hot in normal use)
  - rsp_error_o  out  1  error indication
- **Refill write:**
  - write_valid_i / write_ready_o  in / out  1  write handshake
  - write_addr_i  in  COUNT_ALIGN  set index
  - write_way_i  in  WAY_COUNT  way-enable mask
  - write_tag_i  in  TAG_WIDTH  tag
  - write_error_i  in  1  refill error flag to store
- **Status:** busy_o  out  1  INIT or FLUSH in progress

## Operation

- **Entry format:** {valid, error, tag} (TAG_WIDTH+2 bits), one tc_sram_impl per way, Latency 1, one port.
- **State machine:**
  - INIT: entered on reset; walks lines 0..LINE_COUNT-1 writing all-zero to every way → IDLE.
  - IDLE: services writes and lookups.
  - FLUSH: same walk as INIT; on last line pulses flush_ready_o → IDLE.
- **Flush entry:** FLUSH is entered from IDLE when flush_valid_i=1 and no response is stalled.
- **Line counter:** COUNT_ALIGN bits, cleared on entry to INIT/FLUSH.
- **Priority in IDLE:** flush > write > lookup.
  - write_ready_o = IDLE & ~flush_valid_i & ~stall
  - lookup_ready_o = IDLE & ~flush_valid_i & ~write_valid_i & ~stall
  - stall = rsp_valid_o & ~rsp_ready_i
- **Stall rule:** while stall, no SRAM request is issued, so SRAM read data holds.
- **Write:**
  - Enables only ways set in write_way_i; stores {1, write_error_i, write_tag_i}.
  - write_way_i=0 is accepted as a no-op.
- **Lookup:**
  - Reads all ways at lookup_addr_i; lookup_tag_i is captured into the response stage.
  - Way i hits when valid=1 and tag equals the captured tag.
  - rsp_way_o is the per-way hit vector; rsp_hit_o is its OR.
  - rsp_error_o = OR of error bits of hitting ways, or more than one way hitting.
- **Response stage:** rsp_* are forced to 0 when rsp_valid_o=0.
- **Hazards:**
  - A lookup accepted the cycle after a write to the same line returns the new data.
  - A write accepted while a response is pending does not alter that pending response (it cannot issue until the stall clears).
- **Reset mid-operation:** any state returns to INIT and restarts at line 0; a pending response is dropped.

## Timing

- **Reset values:**
  - busy_o=1
  - all other outputs 0, including flush_ready_o, lookup_ready_o, write_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o and rsp_error_o
- **Lookup latency:** accepted at cycle N → rsp_valid_o at N+1.
  - Throughput is one per cycle while rsp_ready_i=1.
- **Write:** takes effect at the clock edge of acceptance; next-cycle reads observe it.
- **INIT/FLUSH duration:** exactly LINE_COUNT cycles.
  - flush_ready_o pulses in the cycle the last line is written.
  - IDLE resumes the following cycle.
  - busy_o=1 throughout.
- **Flush start:** a pending response must complete before FLUSH starts.

## Configuration

- SNITCH_ICACHE_TAG_PARITY_EN defined:
  - Entry width becomes TAG_WIDTH+3, with an even-parity bit over {valid, error, tag}.
  - Writes compute the parity bit; flush writes all zeros, which have valid parity.
  - A lookup way with a parity mismatch is excluded from hit and forces rsp_error_o=1.
- SNITCH_ICACHE_TAG_PARITY_EN undefined: width TAG_WIDTH+2, no parity check.

## Test plan

- **Reset release:** busy_o=1 for 128 cycles (LINE_COUNT=128), lookup_ready_o=0 throughout. Then lookup addr 5 → rsp_hit_o=0, rsp_way_o=0.
- **Write then lookup:** write addr 5, way 4'b0100, tag 0xABCDE. Lookup addr 5 tag 0xABCDE next cycle → rsp_hit_o=1, rsp_way_o=4'b0100, rsp_error_o=0. Tag 0xABCDF → miss.
- **Backpressure:** back-to-back lookups with rsp_ready_i=0 for 3 cycles → rsp_* stable, lookup_ready_o=0, no SRAM request. Release → the second response arrives the next cycle.
- **Multi-hit / error:** same tag written to ways 0 and 2 → rsp_way_o=4'b0101, rsp_error_o=1. Write_error_i=1 on a single way → hit with rsp_error_o=1.
- **Flush:** flush_valid_i raised with a write pending → flush wins. flush_ready_o pulses after 128 cycles; all earlier hits now miss.
- **Reset mid-flush:** assert rst_i mid-flush (cycle 60) → busy_o=1, INIT restarts from line 0 and lasts 128 cycles. With PARITY_EN, a forced parity flip → rsp_hit_o=0, rsp_error_o=1.
